// File: rtl/packet_decoder_stream.sv
// packet_decoder_stream: reassembles IN_W-bit words into (value, column, row) entries queued in a FIFO; define PACKET_DECODER_ROW_DELTA_EN for delta-coded rows
module packet_decoder_stream #(
  parameter int IN_W  = 64,
  parameter int VAL_W = 64,
  parameter int IDX_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [IN_W-1:0]          data,
  input  logic                     push_in,
  output logic                     in_ready,
  output logic [VAL_W-1:0]         value,
  output logic [IDX_W-1:0]         column,
  output logic [IDX_W-1:0]         row,
  output logic                     push_out,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow
);
  localparam int PKT_W = VAL_W + 2 * IDX_W;
  localparam int WORDS = PKT_W / IN_W;
  localparam int WW    = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = AW + 1;
  logic [WW-1:0]    widx;
  logic [PKT_W-1:0] pkt_buf, pkt, entry, head;
  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [FW-1:0]    cnt;
  logic [IDX_W-1:0] row_dec;
  logic             last, accept, wr, rd;
  assign last     = widx == WW'(WORDS - 1);
  assign in_ready = !last || cnt < FW'(DEPTH);
  assign accept   = push_in && in_ready && !clear;
  assign wr       = accept && last;
  assign push_out = cnt != '0;
  assign rd       = pop && push_out && !clear;
  assign fill     = cnt;
  always_comb begin
    pkt = pkt_buf;
    pkt[widx * IN_W +: IN_W] = data;
  end
`ifdef PACKET_DECODER_ROW_DELTA_EN
  logic [IDX_W-1:0] acc;
  assign row_dec = acc + pkt[IDX_W-1:0];
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc <= '0;
    else if (clear) acc <= '0;
    else if (wr) acc <= row_dec;
`else
  assign row_dec = pkt[IDX_W-1:0];
`endif
  assign entry = {pkt[PKT_W-1:IDX_W], row_dec};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      widx     <= '0;
      pkt_buf  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_in && !in_ready) overflow <= 1'b1;
      if (clear) begin
        widx   <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (accept) begin
          pkt_buf <= pkt;
          widx    <= last ? '0 : widx + 1'b1;
        end
        if (wr) wr_ptr <= wr_ptr + 1'b1;
        if (rd) rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + FW'(wr) - FW'(rd);
      end
    end
  end
  // storage needs no reset: the head is gated to zero while the FIFO is empty
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= entry;
  assign head   = mem[rd_ptr];
  assign value  = push_out ? head[PKT_W-1 -: VAL_W] : '0;
  assign column = push_out ? head[2*IDX_W-1:IDX_W] : '0;
  assign row    = push_out ? head[IDX_W-1:0] : '0;
endmodule

// File: tb/tb_packet_decoder_stream.sv
// tb_packet_decoder_stream: table vectors, corner sequences and random traffic against a queue-based reference model
module tb_packet_decoder_stream;
  localparam int WORDS = 2;
  localparam int DEPTH = 4;
  logic        clk = 0, reset = 0, clear = 0, push_in = 0, pop = 0;
  logic [63:0] data = '0;
  logic        in_ready, push_out, overflow;
  logic [63:0] value;
  logic [31:0] column, row;
  logic [2:0]  fill;
  logic        d2_push = 0, d2_ready, d2_po, d2_ovf;
  logic [31:0] d2_data = '0, d2_val;
  logic [15:0] d2_col, d2_row;
  logic [2:0]  d2_fill;
  always #5 clk = ~clk;
  packet_decoder_stream dut (
    .clk(clk), .reset(reset), .clear(clear), .data(data), .push_in(push_in),
    .in_ready(in_ready), .value(value), .column(column), .row(row),
    .push_out(push_out), .pop(pop), .fill(fill), .overflow(overflow)
  );
  packet_decoder_stream #(.IN_W(32), .VAL_W(32), .IDX_W(16), .DEPTH(4)) d2 (
    .clk(clk), .reset(reset), .clear(1'b0), .data(d2_data), .push_in(d2_push),
    .in_ready(d2_ready), .value(d2_val), .column(d2_col), .row(d2_row),
    .push_out(d2_po), .pop(1'b0), .fill(d2_fill), .overflow(d2_ovf)
  );
  int checks = 0, errors = 0;
  logic [127:0] q[$];
  logic [127:0] part;
  int           nw;
  logic         ovf;
  logic [31:0]  acc;
  typedef struct {
    logic push; logic [63:0] data; logic pop;
    logic e_ready; logic e_po; logic [2:0] e_fill;
    logic [31:0] e_row, e_col; logic [63:0] e_val;
  } vec_t;
  vec_t tbl[4];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic m_ready();
    return (nw != WORDS - 1) || (q.size() < DEPTH);
  endfunction
  task automatic model_reset();
    q.delete(); part = '0; nw = 0; ovf = 0; acc = '0;
  endtask
  task automatic compare();
    logic [127:0] h;
    h = q.size() != 0 ? q[0] : '0;
    chk("in_ready", in_ready, m_ready());
    chk("push_out", push_out, q.size() != 0);
    chk("fill", fill, q.size());
    chk("overflow", overflow, ovf);
    chk("value", value, h[127:64]);
    chk("column", column, h[63:32]);
    chk("row", row, h[31:0]);
  endtask
  task automatic step(input logic p, input logic [63:0] d, input logic pp, input logic c);
    logic rdy;
    logic [31:0] r;
    push_in = p; data = d; pop = pp; clear = c;
    compare();
    @(posedge clk);
    rdy = m_ready();
    if (p && !rdy) ovf = 1;
    if (c) begin
      q.delete(); nw = 0; acc = '0;
    end else begin
      if (pp && q.size() != 0) void'(q.pop_front());
      if (p && rdy) begin
        part[nw*64 +: 64] = d;
        if (nw == WORDS - 1) begin
          r = part[31:0];
`ifdef PACKET_DECODER_ROW_DELTA_EN
          r = acc + r;
          acc = r;
`endif
          q.push_back({part[127:32], r});
          nw = 0;
        end else nw++;
      end
    end
    #1;
  endtask
  initial begin
    tbl[0] = '{1, 64'h0000_0005_0000_0003, 1, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 64'h4010_0000_0000_0000, 1, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 64'h0, 1, 1, 1, 1, 32'd3, 32'd5, 64'h4010_0000_0000_0000};
    tbl[3] = '{0, 64'h0, 0, 1, 0, 0, 0, 0, 0};
    model_reset();
    #12 reset = 1;
    @(posedge clk); #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_push_out", push_out, 0);
    chk("rst_fill", fill, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_po", i), push_out, tbl[i].e_po);
      chk($sformatf("tbl%0d_fill", i), fill, tbl[i].e_fill);
      chk($sformatf("tbl%0d_row", i), row, tbl[i].e_row);
      chk($sformatf("tbl%0d_col", i), column, tbl[i].e_col);
      chk($sformatf("tbl%0d_val", i), value, tbl[i].e_val);
      step(tbl[i].push, tbl[i].data, tbl[i].pop, 0);
    end
    // fill the FIFO, then present a final word with no space
    for (int i = 0; i < 9; i++) step(1, {$urandom, $urandom}, 0, 0);
    chk("full_ready", in_ready, 0);
    chk("full_fill", fill, 4);
    step(1, 64'h1111_2222_3333_4444, 0, 0);
    chk("drop_ovf", overflow, 1);
    chk("drop_fill", fill, 4);
    chk("drop_ready", in_ready, 0);
    step(0, 0, 1, 0);
    chk("pop_ready", in_ready, 1);
    chk("pop_fill", fill, 3);
    step(1, 64'h1111_2222_3333_4444, 0, 0);
    chk("resend_fill", fill, 4);
    chk("sticky_ovf", overflow, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    // clear together with pop and a word, mid-packet with two entries queued
    for (int i = 0; i < 5; i++) step(1, {$urandom, $urandom}, 0, 0);
    chk("pre_clear_fill", fill, 2);
    step(1, {$urandom, $urandom}, 1, 1);
    chk("clear_fill", fill, 0);
    chk("clear_po", push_out, 0);
    chk("clear_ovf", overflow, 1);
    step(1, 64'h0000_0009_0000_0007, 0, 0);
    step(1, 64'hABCD_0000_1234_5678, 0, 0);
    chk("post_clear_po", push_out, 1);
    chk("post_clear_row", row, 7);
    chk("post_clear_col", column, 9);
    chk("post_clear_val", value, 64'hABCD_0000_1234_5678);
`ifdef PACKET_DECODER_ROW_DELTA_EN
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, {32'd100 + 32'(i), i == 0 ? 32'd3 : i == 1 ? 32'd0 : 32'd7}, 0, 0);
      step(1, 64'(i), 0, 0);
    end
    chk("delta_row0", row, 3); step(0, 0, 1, 0);
    chk("delta_row1", row, 3); step(0, 0, 1, 0);
    chk("delta_row2", row, 10); step(0, 0, 1, 1);
    step(1, {32'd1, 32'd2}, 0, 0);
    step(1, 64'd5, 0, 0);
    chk("delta_after_clear", row, 2);
`endif
    // async reset between edges, with a queued entry and a partial packet
    step(1, {$urandom, $urandom}, 0, 0);
    chk("pre_rst_po", push_out, 1);
    #2 reset = 0;
    #1;
    chk("arst_po", push_out, 0);
    chk("arst_fill", fill, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_ovf", overflow, 0);
    chk("arst_val", value, 0);
    chk("arst_row", row, 0);
    model_reset();
    #1 reset = 1;
    step(1, 64'h0000_0002_0000_0001, 0, 0);
    step(1, 64'h0000_0000_DEAD_0001, 0, 0);
    chk("restart_row", row, 1);
    chk("restart_col", column, 2);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    compare();
    // narrow configuration: 2 words per packet with idle gaps between them
    push_in = 0; pop = 0; clear = 0;
    d2_data = 32'h0002_0001; d2_push = 1;
    @(posedge clk); #1;
    d2_push = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("d2_idle_po", d2_po, 0);
    d2_data = 32'hDEAD_BEEF; d2_push = 1;
    @(posedge clk); #1;
    d2_push = 0;
    chk("d2_po", d2_po, 1);
    chk("d2_row", d2_row, 16'h0001);
    chk("d2_col", d2_col, 16'h0002);
    chk("d2_val", d2_val, 32'hDEAD_BEEF);
    chk("d2_fill", d2_fill, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
